// File: rtl/sram_pkg.sv
// Shared definitions for the instruction-memory SRAM write controller:
// FSM states, word-address width and default strobe timing.
package sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    HOLD,
    DONE
  } state_t;

  localparam int unsigned WORD_AW       = 10;
  localparam int unsigned DEF_SETUP_CYC = 1;
  localparam int unsigned DEF_PULSE_CYC = 2;
  localparam int unsigned DEF_HOLD_CYC  = 1;
  localparam int unsigned DEF_CNT_W     = 4;

endpackage

// File: rtl/sram_word_writer.sv
// Writes one 32-bit word to the dual 16-bit async SRAM pair (low half to chip A,
// high half to chip B) with programmable setup / write-pulse / hold cycle counts.
module sram_word_writer
  import sram_pkg::*;
#(
  parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
  parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
  parameter int unsigned HOLD_CYC  = DEF_HOLD_CYC,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_req,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_be,
  output logic        wr_ready,
  output logic        wr_done,
  output logic [31:0] rom_addr,
  output logic [15:0] wdata_a,
  output logic [15:0] wdata_b,
  output logic        data_oe,
  output logic        ce_n,
  output logic        we_n,
  output logic        oe_n,
  output logic        lb_n_a,
  output logic        ub_n_a,
  output logic        lb_n_b,
  output logic        ub_n_b
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       lane_n;
  logic             unused_addr_bits;

  // Only the word index inside the 4 KiB window is used; higher bits alias.
  assign unused_addr_bits = ^{wr_addr[31:12], wr_addr[1:0]};

  assign oe_n   = 1'b1;
  assign lb_n_a = lane_n[0];
  assign ub_n_a = lane_n[1];
  assign lb_n_b = lane_n[2];
  assign ub_n_b = lane_n[3];

  // Outputs are assigned on the transition into each phase so every strobe
  // comes straight from a flop and tracks the state register cycle for cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      wr_ready <= 1'b1;
      wr_done  <= 1'b0;
      rom_addr <= '0;
      wdata_a  <= '0;
      wdata_b  <= '0;
      data_oe  <= 1'b0;
      ce_n     <= 1'b1;
      we_n     <= 1'b1;
      lane_n   <= '1;
    end else begin
      wr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            rom_addr <= {20'h00000, wr_addr[WORD_AW+1:2], 2'b00};
            wdata_a  <= wr_data[15:0];
            wdata_b  <= wr_data[31:16];
            wr_ready <= 1'b0;
            if (wr_be == 4'h0) begin
              state   <= DONE;
              wr_done <= 1'b1;
            end else begin
              state   <= SETUP;
              cnt     <= CNT_W'(SETUP_CYC - 1);
              ce_n    <= 1'b0;
              data_oe <= 1'b1;
              lane_n  <= ~wr_be;
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state <= PULSE;
            cnt   <= CNT_W'(PULSE_CYC - 1);
            we_n  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            state <= HOLD;
            cnt   <= CNT_W'(HOLD_CYC - 1);
            we_n  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state   <= DONE;
            ce_n    <= 1'b1;
            data_oe <= 1'b0;
            lane_n  <= '1;
            wr_done <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state    <= IDLE;
          wr_ready <= 1'b1;
        end
        default: begin
          state    <= IDLE;
          wr_ready <= 1'b1;
          ce_n     <= 1'b1;
          we_n     <= 1'b1;
          data_oe  <= 1'b0;
          lane_n   <= '1;
        end
      endcase
    end
  end

endmodule

// File: doc/sram_word_writer.md
Name: sram_word_writer

Overview:
- Write-side controller for the dual 16-bit asynchronous SRAM pair that backs instruction memory; the existing instruction path reads this pair.
- Accepts one 32-bit word per request and writes the low half to chip A and the high half to chip B in a single shared strobe cycle.
- Sequences setup, write pulse and hold with programmable cycle counts.
- Used by the program loader and by store paths that target instruction memory.

Parameters:
- SETUP_CYC, 1, cycles with address, data and chip enable stable before we_n falls (≥1).
- PULSE_CYC, 2, cycles we_n is held low (≥1).
- HOLD_CYC, 1, cycles address and data stay driven after we_n rises (≥1).
- CNT_W, 4, width of the phase counter; must hold max(SETUP_CYC, PULSE_CYC, HOLD_CYC).

Ports:
- clk  in  1  system clock, same domain as the SRAM strobes.
- rst  in  1  asynchronous, active-low reset.
- wr_req  in  1  write request, sampled when wr_ready=1.
- wr_addr  in  32  byte address; only bits [11:2] are used.
- wr_data  in  32  word to write; [15:0] goes to chip A, [31:16] to chip B.
- wr_be  in  4  byte enables; bit0/1 map to chip A low/high byte, bit2/3 to chip B low/high byte.
- wr_ready  out  1  high only in IDLE.
- wr_done  out  1  single-cycle pulse when the write is complete.
- rom_addr  out  32  SRAM word address, {20'h00000, addr[11:2], 2'b00}.
- wdata_a  out  16  chip A write data.
- wdata_b  out  16  chip B write data.
- data_oe  out  1  tristate enable for the wdata buses.
- ce_n  out  1  shared chip enable, active low.
- we_n  out  1  shared write enable, active low.
- oe_n  out  1  output enable, active low; constant 1 in this block.
- lb_n_a, ub_n_a, lb_n_b, ub_n_b  out  1 each  byte lanes, active low, equal to ~wr_be bits during a cycle.

Behaviour:
- Reset values: wr_ready=1, wr_done=0, ce_n=1, we_n=1, oe_n=1, data_oe=0, all lane signals 1, rom_addr=0, wdata=0, state=IDLE.
  - Reset is asynchronous and takes effect mid-cycle.
  - Strobes go inactive immediately; no completion pulse is issued for the aborted write.
- Registered outputs: every SRAM-side output comes from a flop, so there are no combinational glitches on we_n or ce_n.
- IDLE:
  - When wr_req=1, latch address, data and byte enables.
  - If wr_be=0, go to DONE and skip the SRAM access.
  - Otherwise go to SETUP with the counter loaded to SETUP_CYC-1.
- SETUP: ce_n=0, data_oe=1, lanes driven, we_n=1; decrement the counter; at 0 go to PULSE with the counter loaded to PULSE_CYC-1.
- PULSE: as SETUP but we_n=0; at 0 go to HOLD with the counter loaded to HOLD_CYC-1.
- HOLD: we_n=1, ce_n=0, data_oe=1, address and data unchanged; at 0 go to DONE.
- DONE: ce_n=1, data_oe=0, lanes=1, wr_done=1 for exactly one cycle; next state IDLE.
- Latency:
  - Request accepted at edge T; wr_done is high in cycle T+1+SETUP_CYC+PULSE_CYC+HOLD_CYC. With defaults this is T+5.
  - wr_be=0 gives wr_done at T+1.
- Back-to-back requests: a new request is accepted no earlier than the cycle after DONE, so minimum spacing is SETUP_CYC+PULSE_CYC+HOLD_CYC+2 cycles.
- Request handling:
  - wr_req while busy is ignored, and inputs are not re-sampled.
  - The requester holds wr_req until it sees wr_ready.
- Invariants:
  - Address, data and lane signals are constant whenever we_n=0 or ce_n=0 within a transaction.
  - we_n is never 0 while ce_n=1 or data_oe=0.
- Address wrap: addresses above 0xFFF alias modulo 4 KiB because only bits [11:2] are used; no error is flagged.

Decomposition:
- Shared package (sram_pkg):
  - FSM state enum (IDLE, SETUP, PULSE, HOLD, DONE).
  - SRAM word-address width (10).
  - Default timing constants.
- No sub-module: a single FSM plus one down-counter. A second instance of this block is not needed, because both chips share the strobes.

Test Plan:
- Basic write: after reset, write addr=0x0000_0104, data=0xDEAD_BEEF, be=4'hF → rom_addr=0x104, wdata_a=0xBEEF, wdata_b=0xDEAD, we_n low for exactly 2 cycles, wr_done at T+5, wr_ready low for T+1..T+5.
- Byte enables: be=4'b0110 → lb_n_a=1, ub_n_a=0, lb_n_b=0, ub_n_b=1 across SETUP..HOLD; all lanes return to 1 in DONE.
- Empty write: be=4'h0 → ce_n and we_n never fall, wr_done at T+1.
- Request while busy: second wr_req with data=0x1234_5678 issued during PULSE → ignored; SRAM still sees 0xDEAD_BEEF; the second write is accepted only after wr_ready returns.
- Address alias: addr=0x0000_1FFC → rom_addr=0x0000_0FFC.
- Reset mid-cycle: assert rst=0 during PULSE → we_n=1, ce_n=1, data_oe=0 within the same cycle, no wr_done pulse, wr_ready=1 after release.
